// File: rtl/gfx_fb_writer.sv
// Framebuffer pixel sink: registers the linear address of each accepted pixel,
// queues in-range pixels in a small FWFT FIFO and replays them as async SRAM write cycles.
module gfx_fb_writer #(
   parameter int FB_WIDTH   = 640,
   parameter int FB_HEIGHT  = 480,
   parameter int COLOR_BITS = 12,
   parameter int ADDR_BITS  = 20,
   parameter int FIFO_DEPTH = 4,
   localparam int X_BITS    = $clog2(FB_WIDTH),
   localparam int Y_BITS    = $clog2(FB_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [X_BITS-1:0]     pix_x,
   input  logic [Y_BITS-1:0]     pix_y,
   input  logic [COLOR_BITS-1:0] pix_color,
   output logic [ADDR_BITS-1:0]  sram_addr,
   output logic [COLOR_BITS-1:0] sram_data,
   output logic                  sram_data_oe,
   output logic                  sram_we_n,
   output logic                  idle,
   output logic [15:0]           drop_count,
   output logic [1:0]            fsm_state
);

   localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS   = PTR_BITS + 1;
   localparam int ENTRY_BITS = ADDR_BITS + COLOR_BITS;

   localparam logic [X_BITS:0]   X_LIMIT = (X_BITS + 1)'(FB_WIDTH);
   localparam logic [Y_BITS:0]   Y_LIMIT = (Y_BITS + 1)'(FB_HEIGHT);
   localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(FIFO_DEPTH);

   // Valid/ready: a pixel transfers on a rising edge where pix_valid && pix_ready.
   // pix_ready never depends on pix_valid, so the drawer may use it as its enable.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t state, state_next;

   logic                    reset_q;
   logic                    accept;
   logic                    a_valid;
   logic                    a_in_range;
   logic [ADDR_BITS-1:0]    a_addr;
   logic [COLOR_BITS-1:0]   a_color;

   logic [ENTRY_BITS-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]     wr_ptr;
   logic [PTR_BITS-1:0]     rd_ptr;
   logic [CNT_BITS-1:0]     fifo_count;
   logic [CNT_BITS-1:0]     pending;
   logic [ENTRY_BITS-1:0]   head;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;

   always_ff @(posedge clk) begin
      reset_q <= reset;
   end

   // Counting the occupied stage A slot keeps its push from ever meeting a full FIFO.
   assign pending   = fifo_count + CNT_BITS'(a_valid);
   assign pix_ready = !reset && !reset_q && (pending < DEPTH_C);
   assign accept    = pix_valid && pix_ready;

   // Stage A: address register
   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid    <= 1'b0;
         a_in_range <= 1'b0;
         a_addr     <= '0;
         a_color    <= '0;
      end else begin
         a_valid <= accept;
         if (accept) begin
            a_addr     <= ADDR_BITS'(pix_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(pix_x);
            a_color    <= pix_color;
            a_in_range <= ({1'b0, pix_x} < X_LIMIT) && ({1'b0, pix_y} < Y_LIMIT);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (a_valid && !a_in_range && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   // FIFO (first-word-fall-through)
   assign push       = a_valid && a_in_range;
   assign fifo_empty = (fifo_count == '0);
   assign head       = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {a_addr, a_color};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_BITS'(1);
            2'b01:   fifo_count <= fifo_count - CNT_BITS'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Write FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_next = ST_SETUP;
               pop        = 1'b1;
            end
         end
         ST_SETUP:  state_next = ST_STROBE;
         ST_STROBE: state_next = ST_HOLD;
         ST_HOLD: begin
            if (!fifo_empty) begin
               state_next = ST_SETUP;
               pop        = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // SRAM pins are registered from the next state so the strobe is glitch-free and
   // address/data only move on SETUP entry, never on a we_n edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sram_we_n    <= 1'b1;
         sram_data_oe <= 1'b0;
         sram_addr    <= '0;
         sram_data    <= '0;
      end else begin
         sram_we_n    <= (state_next != ST_STROBE);
         sram_data_oe <= (state_next != ST_IDLE);
         if (pop) begin
            sram_addr <= head[ENTRY_BITS-1:COLOR_BITS];
            sram_data <= head[COLOR_BITS-1:0];
         end
      end
   end

   assign idle      = !a_valid && fifo_empty && (state == ST_IDLE);
   assign fsm_state = state;

endmodule
